// File: rtl/sdram_mux.sv
// N-client SDRAM request multiplexer: arbitrates client requests onto one controller
// port and steers in-order read returns back to the issuing client through a tag FIFO.
module sdram_mux #(
   parameter int N     = 2,
   parameter int AW    = 24,
   parameter int DW    = 16,
   parameter int MODE  = 0,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    cli_req,
   input  logic [N-1:0]    cli_we,
   input  logic [N*AW-1:0] cli_addr,
   input  logic [N*DW-1:0] cli_data,
   output logic [N-1:0]    cli_ack,
   output logic [N-1:0]    cli_rvalid,
   output logic [DW-1:0]   rdata,
   output logic            if_req,
   output logic            if_we,
   output logic [AW-1:0]   if_addr,
   output logic [DW-1:0]   if_data,
   input  logic            if_rdy,
   input  logic            if_rdy_out,
   input  logic [DW-1:0]   if_data_out,
   output logic            busy,
   output logic            err
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = $clog2(DEPTH);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   gnt_q, gnt_d, rr_q, rr_d;
   logic            if_req_q, if_req_d, if_we_q, if_we_d;
   logic [AW-1:0]   if_addr_q, if_addr_d;
   logic [DW-1:0]   if_data_q, if_data_d, rdata_q, rdata_d;
   logic [N-1:0]    ack_q, ack_d, rvalid_q, rvalid_d;
   logic            err_q, err_d;
   logic [IW-1:0]   tag_mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]     cnt_q, cnt_d;
   logic            push, pop, full, found;
   logic [N-1:0]    elig;
   logic [IW-1:0]   idx, pick;

   assign full = (cnt_q == (PW+1)'(DEPTH));

   // Handshake: if_req/if_we/if_addr/if_data stay frozen from grant until the cycle
   // if_rdy is high; cli_req must be held until that client's one-cycle cli_ack.
   always_comb begin
      elig  = '0;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      if (ack_q == '0) elig = cli_req & (full ? cli_we : {N{1'b1}});
      for (int j = 0; j < N; j++) begin
         if (MODE == 0) idx = IW'(j);
         else           idx = IW'((int'(rr_q) + j) % N);
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      rr_d      = rr_q;
      if_req_d  = if_req_q;
      if_we_d   = if_we_q;
      if_addr_d = if_addr_q;
      if_data_d = if_data_q;
      ack_d     = '0;
      push      = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d     = pick;
               if_req_d  = 1'b1;
               if_we_d   = cli_we[pick];
               if_addr_d = cli_addr[int'(pick)*AW +: AW];
               if_data_d = cli_data[int'(pick)*DW +: DW];
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (if_rdy) begin
               if_req_d     = 1'b0;
               ack_d[gnt_q] = 1'b1;
               push         = !if_we_q;
               if (MODE != 0) rr_d = (gnt_q == IW'(N-1)) ? '0 : gnt_q + IW'(1);
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read return path; a return with no tag outstanding is dropped and flagged.
   always_comb begin
      pop      = if_rdy_out && (cnt_q != '0);
      rvalid_d = '0;
      rdata_d  = rdata_q;
      err_d    = err_q | (if_rdy_out && (cnt_q == '0));
      if (pop) begin
         rdata_d                       = if_data_out;
         rvalid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
      end
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_d    = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         rr_q      <= '0;
         if_req_q  <= 1'b0;
         if_we_q   <= 1'b0;
         if_addr_q <= '0;
         if_data_q <= '0;
         ack_q     <= '0;
         rvalid_q  <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         rr_q      <= rr_d;
         if_req_q  <= if_req_d;
         if_we_q   <= if_we_d;
         if_addr_q <= if_addr_d;
         if_data_q <= if_data_d;
         ack_q     <= ack_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem_q[wr_ptr_q] <= gnt_q;
   end

   assign cli_ack    = ack_q;
   assign cli_rvalid = rvalid_q;
   assign rdata      = rdata_q;
   assign if_req     = if_req_q;
   assign if_we      = if_we_q;
   assign if_addr    = if_addr_q;
   assign if_data    = if_data_q;
   assign busy       = (state_q == ISSUE);
   assign err        = err_q;

endmodule

// File: tb/tb_sdram_mux.sv
// Bench for sdram_mux: a round-robin/depth-2 instance and a fixed-priority/depth-4
// instance, driven by random clients and controllers and checked against a reference model.
module tb_sdram_mux;
   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst     [2];
   logic [N-1:0]    c_req   [2];
   logic [N-1:0]    c_we    [2];
   logic [N*AW-1:0] c_addr  [2];
   logic [N*DW-1:0] c_data  [2];
   logic [N-1:0]    d_ack   [2];
   logic [N-1:0]    d_rv    [2];
   logic [DW-1:0]   d_rdata [2];
   logic            d_req   [2];
   logic            d_we    [2];
   logic [AW-1:0]   d_addr  [2];
   logic [DW-1:0]   d_wdata [2];
   logic            rdy     [2];
   logic            rdy_out [2];
   logic [DW-1:0]   dout    [2];
   logic            d_busy  [2];
   logic            d_err   [2];

   sdram_mux #(.N(N), .AW(AW), .DW(DW), .MODE(1), .DEPTH(2)) u_rr (
      .clk(clk), .reset(rst[0]), .cli_req(c_req[0]), .cli_we(c_we[0]),
      .cli_addr(c_addr[0]), .cli_data(c_data[0]), .cli_ack(d_ack[0]),
      .cli_rvalid(d_rv[0]), .rdata(d_rdata[0]), .if_req(d_req[0]), .if_we(d_we[0]),
      .if_addr(d_addr[0]), .if_data(d_wdata[0]), .if_rdy(rdy[0]),
      .if_rdy_out(rdy_out[0]), .if_data_out(dout[0]), .busy(d_busy[0]), .err(d_err[0])
   );

   sdram_mux #(.N(N), .AW(AW), .DW(DW), .MODE(0), .DEPTH(4)) u_fp (
      .clk(clk), .reset(rst[1]), .cli_req(c_req[1]), .cli_we(c_we[1]),
      .cli_addr(c_addr[1]), .cli_data(c_data[1]), .cli_ack(d_ack[1]),
      .cli_rvalid(d_rv[1]), .rdata(d_rdata[1]), .if_req(d_req[1]), .if_we(d_we[1]),
      .if_addr(d_addr[1]), .if_data(d_wdata[1]), .if_rdy(rdy[1]),
      .if_rdy_out(rdy_out[1]), .if_data_out(dout[1]), .busy(d_busy[1]), .err(d_err[1])
   );

   int n_checks = 0;
   int n_errors = 0;
   int mode_of  [2] = '{1, 0};
   int depth_of [2] = '{2, 4};

   bit gen_en [2];
   bit rst_cmd [2];
   bit force_ret [2];
   bit ret_en;
   logic pend_we [2];

   // reference model state
   bit            m_busy  [2];
   int            m_g     [2];
   int            m_rr    [2];
   logic          m_we    [2];
   logic [AW-1:0] m_addr  [2];
   logic [DW-1:0] m_wdata [2];
   logic [DW-1:0] m_rdata [2];
   logic [N-1:0]  m_ack   [2];
   logic [N-1:0]  m_rv    [2];
   logic          m_err   [2];
   logic [1:0]    exp_q0 [$];
   logic [1:0]    exp_q1 [$];
   logic [DW-1:0] ctl_q0 [$];
   logic [DW-1:0] ctl_q1 [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int tag_cnt(input int k);
      return (k == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic int ctl_cnt(input int k);
      return (k == 0) ? ctl_q0.size() : ctl_q1.size();
   endfunction

   task automatic tag_push(input int k, input logic [1:0] t);
      if (k == 0) exp_q0.push_back(t);
      else        exp_q1.push_back(t);
   endtask

   task automatic tag_pop(input int k, output logic [1:0] t);
      if (k == 0) t = exp_q0.pop_front();
      else        t = exp_q1.pop_front();
   endtask

   task automatic ctl_push(input int k, input logic [DW-1:0] v);
      if (k == 0) ctl_q0.push_back(v);
      else        ctl_q1.push_back(v);
   endtask

   task automatic ctl_pop(input int k, output logic [DW-1:0] v);
      if (k == 0) v = ctl_q0.pop_front();
      else        v = ctl_q1.pop_front();
   endtask

   task automatic flush_q(input int k);
      if (k == 0) begin exp_q0.delete(); ctl_q0.delete(); end
      else        begin exp_q1.delete(); ctl_q1.delete(); end
   endtask

   // first requesting client scanning upward from start, wrapping past N-1
   function automatic int pick_from(input logic [N-1:0] el, input int start);
      for (int j = 0; j < N; j++) begin
         if (el[(start + j) % N]) return (start + j) % N;
      end
      return -1;
   endfunction

   // Advance instance k's model over the edge just past, using the inputs it saw.
   task automatic model_edge(input int k);
      logic [N-1:0] el;
      logic [N-1:0] ack_n;
      logic [N-1:0] rv_n;
      logic [1:0]   t;
      bit           do_push;
      int           g;
      ack_n   = '0;
      rv_n    = '0;
      do_push = 1'b0;
      if (rst[k]) begin
         m_busy[k] = 1'b0; m_ack[k] = '0; m_rv[k] = '0; m_rdata[k] = '0;
         m_err[k] = 1'b0;  m_rr[k] = 0;   m_g[k] = 0;
         if (k == 0) exp_q0.delete(); else exp_q1.delete();
         return;
      end
      if (m_busy[k]) begin
         if (rdy[k]) begin
            ack_n[m_g[k]] = 1'b1;
            do_push = !m_we[k];
            if (mode_of[k] == 1) m_rr[k] = (m_g[k] + 1) % N;
            m_busy[k] = 1'b0;
         end
      end else if (m_ack[k] == '0) begin
         for (int i = 0; i < N; i++)
            el[i] = c_req[k][i] && (c_we[k][i] || tag_cnt(k) < depth_of[k]);
         g = pick_from(el, (mode_of[k] == 1) ? m_rr[k] : 0);
         if (g >= 0) begin
            m_busy[k]  = 1'b1;
            m_g[k]     = g;
            m_we[k]    = c_we[k][g];
            m_addr[k]  = c_addr[k][g*AW +: AW];
            m_wdata[k] = c_data[k][g*DW +: DW];
         end
      end
      if (rdy_out[k]) begin
         if (tag_cnt(k) > 0) begin
            tag_pop(k, t);
            rv_n[t]    = 1'b1;
            m_rdata[k] = dout[k];
         end else begin
            m_err[k] = 1'b1;
         end
      end
      if (do_push) tag_push(k, 2'(m_g[k]));
      m_ack[k] = ack_n;
      m_rv[k]  = rv_n;
   endtask

   task automatic compare(input int k);
      check($sformatf("k%0d busy", k), 32'(d_busy[k]), 32'(m_busy[k]));
      check($sformatf("k%0d if_req", k), 32'(d_req[k]), 32'(m_busy[k]));
      if (m_busy[k]) begin
         check($sformatf("k%0d if_we", k), 32'(d_we[k]), 32'(m_we[k]));
         check($sformatf("k%0d if_addr", k), 32'(d_addr[k]), 32'(m_addr[k]));
         check($sformatf("k%0d if_data", k), 32'(d_wdata[k]), 32'(m_wdata[k]));
      end
      check($sformatf("k%0d cli_ack", k), 32'(d_ack[k]), 32'(m_ack[k]));
      check($sformatf("k%0d cli_rvalid", k), 32'(d_rv[k]), 32'(m_rv[k]));
      if (m_rv[k] != '0 || rst[k])
         check($sformatf("k%0d rdata", k), 32'(d_rdata[k]), 32'(m_rdata[k]));
      check($sformatf("k%0d err", k), 32'(d_err[k]), 32'(m_err[k]));
   endtask

   // One clock: check the edge just past, then drive inputs for the next edge.
   task automatic step();
      logic [DW-1:0] v;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         model_edge(k);
         compare(k);
         if (rst[k]) flush_q(k);
         else if (rdy[k] && !pend_we[k]) ctl_push(k, DW'($urandom));
      end
      for (int k = 0; k < 2; k++) begin
         rst[k]     = rst_cmd[k];
         rdy[k]     = !rst_cmd[k] && d_req[k] && ($urandom_range(0, 2) == 0);
         pend_we[k] = d_we[k];
         if (force_ret[k]) begin
            rdy_out[k] = 1'b1;
            dout[k]    = DW'($urandom);
         end else if (ret_en && ctl_cnt(k) > 0 && $urandom_range(0, 1) == 0) begin
            ctl_pop(k, v);
            rdy_out[k] = 1'b1;
            dout[k]    = v;
         end else begin
            rdy_out[k] = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (c_req[k][i] && d_ack[k][i]) begin
               c_req[k][i] = 1'b0;
            end else if (!c_req[k][i] && gen_en[k] && $urandom_range(0, 3) == 0) begin
               c_req[k][i]           = 1'b1;
               c_we[k][i]            = 1'($urandom_range(0, 1));
               c_addr[k][i*AW +: AW] = AW'($urandom);
               c_data[k][i*DW +: DW] = DW'($urandom);
            end
         end
      end
   endtask

   initial begin
      bit drained;
      bit done [2];
      ret_en = 1'b1;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; rst_cmd[k] = 1'b1; rdy[k] = 1'b0; rdy_out[k] = 1'b0;
         dout[k] = '0; c_req[k] = '0; c_we[k] = '0; c_addr[k] = '0; c_data[k] = '0;
         gen_en[k] = 1'b0; force_ret[k] = 1'b0; pend_we[k] = 1'b0; done[k] = 1'b0;
         m_busy[k] = 1'b0; m_ack[k] = '0; m_rv[k] = '0; m_err[k] = 1'b0;
         m_g[k] = 0; m_rr[k] = 0; m_rdata[k] = '0;
      end
      repeat (3) step();

      // random traffic, with return-path stalls that fill the tag FIFO
      for (int k = 0; k < 2; k++) begin rst_cmd[k] = 1'b0; gen_en[k] = 1'b1; end
      for (int c = 0; c < 4000; c++) begin
         if (c % 50 == 0) ret_en = ($urandom_range(0, 2) != 0);
         step();
      end

      // drain, then a return with nothing outstanding
      gen_en[0] = 1'b0; gen_en[1] = 1'b0; ret_en = 1'b1;
      drained = 1'b0;
      for (int c = 0; c < 1000 && !drained; c++) begin
         step();
         drained = 1'b1;
         for (int k = 0; k < 2; k++)
            if (c_req[k] != '0 || m_busy[k] || tag_cnt(k) != 0 || ctl_cnt(k) != 0 ||
                m_ack[k] != '0) drained = 1'b0;
      end
      check("drain", 32'(drained), 32'd1);
      force_ret[0] = 1'b1; force_ret[1] = 1'b1;
      step();
      force_ret[0] = 1'b0; force_ret[1] = 1'b0;
      repeat (4) step();
      check("k0 err_sticky", 32'(d_err[0]), 32'd1);
      check("k1 err_sticky", 32'(d_err[1]), 32'd1);

      // reset clears err; then reset again mid-grant with reads outstanding
      rst_cmd[0] = 1'b1; rst_cmd[1] = 1'b1;
      repeat (2) step();
      rst_cmd[0] = 1'b0; rst_cmd[1] = 1'b0;
      gen_en[0] = 1'b1; gen_en[1] = 1'b1; ret_en = 1'b0;
      for (int c = 0; c < 1000 && !(done[0] && done[1]); c++) begin
         for (int k = 0; k < 2; k++) begin
            rst_cmd[k] = 1'b0;
            if (!done[k] && m_busy[k] && tag_cnt(k) >= 1) begin
               rst_cmd[k] = 1'b1;
               done[k]    = 1'b1;
               gen_en[k]  = 1'b0;
               c_req[k]   = '0;
            end
         end
         step();
      end
      rst_cmd[0] = 1'b0; rst_cmd[1] = 1'b0;
      check("k0 reset_hit", 32'(done[0]), 32'd1);
      check("k1 reset_hit", 32'(done[1]), 32'd1);
      step();
      check("k0 err_after_reset", 32'(d_err[0]), 32'd0);
      check("k1 err_after_reset", 32'(d_err[1]), 32'd0);
      force_ret[0] = 1'b1; force_ret[1] = 1'b1;
      step();
      force_ret[0] = 1'b0; force_ret[1] = 1'b0;
      repeat (2) step();
      check("k0 err_stale_return", 32'(d_err[0]), 32'd1);
      check("k1 err_stale_return", 32'(d_err[1]), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
